hyperram_arbiter: RTL and testbench

HYPERRAM_ARBITER -- requirements
Module: hyperram_arbiter

---
 rtl/hyperram_pkg.sv | 23 ++
 rtl/hyperram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hyperram_arbiter.sv | 550 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared types and widths for the HyperRAM requester arbiter.
// Holds arb_state_t, the Avalon bus widths and the burst-length helper.
package hyperram_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 16;
   localparam int BE_W   = 2;
   localparam int BC_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } arb_state_t;

   // A burstcount of zero still moves one beat.
   function automatic logic [BC_W-1:0] eff_burst(
      input logic [BC_W-1:0] bc
   );
      return (bc == '0) ? BC_W'(1) : bc;
   endfunction

endpackage

// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: grants one of two Avalon-MM requesters (s0/s1) the
// shared m port for one transaction; clk_i, rst_ni async active-low.
module hyperram_arbiter
   import hyperram_pkg::*;
#(
   parameter int G_ROUND_ROBIN = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              s0_avm_write_i,
   input  logic              s0_avm_read_i,
   input  logic [ADDR_W-1:0] s0_avm_address_i,
   input  logic [DATA_W-1:0] s0_avm_writedata_i,
   input  logic [BE_W-1:0]   s0_avm_byteenable_i,
   input  logic [BC_W-1:0]   s0_avm_burstcount_i,
   output logic [DATA_W-1:0] s0_avm_readdata_o,
   output logic              s0_avm_readdatavalid_o,
   output logic              s0_avm_waitrequest_o,
   input  logic              s1_avm_write_i,
   input  logic              s1_avm_read_i,
   input  logic [ADDR_W-1:0] s1_avm_address_i,
   input  logic [DATA_W-1:0] s1_avm_writedata_i,
   input  logic [BE_W-1:0]   s1_avm_byteenable_i,
   input  logic [BC_W-1:0]   s1_avm_burstcount_i,
   output logic [DATA_W-1:0] s1_avm_readdata_o,
   output logic              s1_avm_readdatavalid_o,
   output logic              s1_avm_waitrequest_o,
   output logic              m_avm_write_o,
   output logic              m_avm_read_o,
   output logic [ADDR_W-1:0] m_avm_address_o,
   output logic [DATA_W-1:0] m_avm_writedata_o,
   output logic [BE_W-1:0]   m_avm_byteenable_o,
   output logic [BC_W-1:0]   m_avm_burstcount_o,
   input  logic [DATA_W-1:0] m_avm_readdata_i,
   input  logic              m_avm_readdatavalid_i,
   input  logic              m_avm_waitrequest_i
);

   arb_state_t        state;
   logic              last_grant;
   logic              wr_busy;
   logic              rd_busy;
   logic [BC_W-1:0]   beat_cnt;
   logic [BC_W-1:0]   rd_cnt;

   logic              req0;
   logic              req1;
   logic              pick0;
   logic              granted;
   logic              sel;
   logic              g0;
   logic              g1;
   logic              x_write;
   logic              x_read;
   logic [ADDR_W-1:0] x_address;
   logic [DATA_W-1:0] x_writedata;
   logic [BE_W-1:0]   x_byteenable;
   logic [BC_W-1:0]   x_burstcount;
   logic [BC_W-1:0]   x_len;
   logic              x_wait;
   logic              wr_acc;
   logic              rd_acc;
   logic              rd_ret;
   logic              txn_end;

   assign req0 = s0_avm_write_i | s0_avm_read_i;
   assign req1 = s1_avm_write_i | s1_avm_read_i;

   // s0 wins when alone, under fixed priority, or when s1 went last.
   assign pick0 = req0 & (~req1 | (G_ROUND_ROBIN == 0) | last_grant);

   assign granted = (state != ST_IDLE);
   assign g0      = (state == ST_GRANT0);
   assign g1      = (state == ST_GRANT1);
   assign sel     = g1;

   always_comb begin
      if (sel) begin
         x_write      = s1_avm_write_i;
         x_read       = s1_avm_read_i;
         x_address    = s1_avm_address_i;
         x_writedata  = s1_avm_writedata_i;
         x_byteenable = s1_avm_byteenable_i;
         x_burstcount = s1_avm_burstcount_i;
      end else begin
         x_write      = s0_avm_write_i;
         x_read       = s0_avm_read_i;
         x_address    = s0_avm_address_i;
         x_writedata  = s0_avm_writedata_i;
         x_byteenable = s0_avm_byteenable_i;
         x_burstcount = s0_avm_burstcount_i;
      end
   end

   assign x_len = eff_burst(x_burstcount);

   // Command strobes are held off while read data is still owed, and a
   // write takes precedence over a simultaneous read.
   assign m_avm_write_o      = granted & ~rd_busy & x_write;
   assign m_avm_read_o       = granted & ~rd_busy & x_read & ~x_write;
   assign m_avm_address_o    = granted ? x_address : '0;
   assign m_avm_writedata_o  = granted ? x_writedata : '0;
   assign m_avm_byteenable_o = granted ? x_byteenable : '0;
   assign m_avm_burstcount_o = granted ? x_burstcount : '0;

   assign x_wait = rd_busy | m_avm_waitrequest_i;

   assign s0_avm_waitrequest_o = g0 ? x_wait : 1'b1;
   assign s1_avm_waitrequest_o = g1 ? x_wait : 1'b1;

   // rd_busy is only ever set inside a grant, so stray returns are dropped.
   assign rd_ret = rd_busy & m_avm_readdatavalid_i;

   assign s0_avm_readdatavalid_o = g0 & rd_ret;
   assign s1_avm_readdatavalid_o = g1 & rd_ret;
   assign s0_avm_readdata_o = (g0 & rd_busy) ? m_avm_readdata_i : '0;
   assign s1_avm_readdata_o = (g1 & rd_busy) ? m_avm_readdata_i : '0;

   assign wr_acc = m_avm_write_o & ~m_avm_waitrequest_i;
   assign rd_acc = m_avm_read_o & ~m_avm_waitrequest_i;

   // beat_cnt holds beats still owed after the one being accepted.
   always_comb begin
      txn_end = 1'b0;
      if (wr_acc) begin
         if (wr_busy) begin
            txn_end = (beat_cnt <= BC_W'(1));
         end else begin
            txn_end = (x_len == BC_W'(1));
         end
      end
      if (rd_ret && (rd_cnt <= BC_W'(1))) begin
         txn_end = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         wr_busy    <= 1'b0;
         rd_busy    <= 1'b0;
         beat_cnt   <= '0;
         rd_cnt     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (pick0) begin
                  state <= ST_GRANT0;
               end else if (req1) begin
                  state <= ST_GRANT1;
               end
            end
            ST_GRANT0, ST_GRANT1: begin
               if (txn_end) begin
                  state      <= ST_IDLE;
                  last_grant <= sel;
                  wr_busy    <= 1'b0;
                  rd_busy    <= 1'b0;
                  beat_cnt   <= '0;
                  rd_cnt     <= '0;
               end else begin
                  if (wr_acc) begin
                     wr_busy  <= 1'b1;
                     beat_cnt <= wr_busy ? beat_cnt - BC_W'(1)
                                         : x_len - BC_W'(1);
                  end
                  if (rd_acc) begin
                     rd_busy <= 1'b1;
                     rd_cnt  <= x_len;
                  end
                  if (rd_ret) begin
                     rd_cnt <= rd_cnt - BC_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: randomized scoreboard bench for hyperram_arbiter.
// Grant order comes from a transaction-level model; monitors pop queues.
module tb_hyperram_arbiter;

   localparam int RR = 1;

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [15:0] d0;
      logic [1:0]  be;
      logic [7:0]  bc;
   } txn_t;

   typedef struct packed {
      logic        port;
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
      logic [7:0]  bc;
   } mcmd_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  s_wr;
   logic [1:0]  s_rd;
   logic [31:0] s_addr [2];
   logic [15:0] s_wd [2];
   logic [1:0]  s_be [2];
   logic [7:0]  s_bc [2];
   logic [15:0] s_rdata [2];
   logic [1:0]  s_rdv;
   logic [1:0]  s_wait;
   logic        m_wr;
   logic        m_rd;
   logic [31:0] m_addr;
   logic [15:0] m_wd;
   logic [1:0]  m_be;
   logic [7:0]  m_bc;
   logic [15:0] m_rdata;
   logic        m_rdv;
   logic        m_wait;

   logic        f_wr0;
   logic        f_wr1;
   logic [31:0] f_a0;
   logic [31:0] f_a1;
   logic [15:0] f_d0;
   logic [15:0] f_d1;
   logic [15:0] f_rd0;
   logic [15:0] f_rd1;
   logic        f_v0;
   logic        f_v1;
   logic        f_w0;
   logic        f_w1;
   logic        f_mwr;
   logic        f_mrd;
   logic [31:0] f_maddr;
   logic [15:0] f_mwd;
   logic [1:0]  f_mbe;
   logic [7:0]  f_mbc;

   int          checks;
   int          errors;
   bit          last_g;
   bit          slave_hold;
   mcmd_t       exp_m [$];
   logic [15:0] exp_rd0 [$];
   logic [15:0] exp_rd1 [$];
   logic [15:0] ret_q [$];
   mcmd_t       mon_e;

   always #5 clk = ~clk;

   hyperram_arbiter #(.G_ROUND_ROBIN(RR)) u_dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .s0_avm_write_i         (s_wr[0]),
      .s0_avm_read_i          (s_rd[0]),
      .s0_avm_address_i       (s_addr[0]),
      .s0_avm_writedata_i     (s_wd[0]),
      .s0_avm_byteenable_i    (s_be[0]),
      .s0_avm_burstcount_i    (s_bc[0]),
      .s0_avm_readdata_o      (s_rdata[0]),
      .s0_avm_readdatavalid_o (s_rdv[0]),
      .s0_avm_waitrequest_o   (s_wait[0]),
      .s1_avm_write_i         (s_wr[1]),
      .s1_avm_read_i          (s_rd[1]),
      .s1_avm_address_i       (s_addr[1]),
      .s1_avm_writedata_i     (s_wd[1]),
      .s1_avm_byteenable_i    (s_be[1]),
      .s1_avm_burstcount_i    (s_bc[1]),
      .s1_avm_readdata_o      (s_rdata[1]),
      .s1_avm_readdatavalid_o (s_rdv[1]),
      .s1_avm_waitrequest_o   (s_wait[1]),
      .m_avm_write_o          (m_wr),
      .m_avm_read_o           (m_rd),
      .m_avm_address_o        (m_addr),
      .m_avm_writedata_o      (m_wd),
      .m_avm_byteenable_o     (m_be),
      .m_avm_burstcount_o     (m_bc),
      .m_avm_readdata_i       (m_rdata),
      .m_avm_readdatavalid_i  (m_rdv),
      .m_avm_waitrequest_i    (m_wait)
   );

   hyperram_arbiter #(.G_ROUND_ROBIN(0)) u_fix (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .s0_avm_write_i         (f_wr0),
      .s0_avm_read_i          (1'b0),
      .s0_avm_address_i       (f_a0),
      .s0_avm_writedata_i     (f_d0),
      .s0_avm_byteenable_i    (2'b11),
      .s0_avm_burstcount_i    (8'd1),
      .s0_avm_readdata_o      (f_rd0),
      .s0_avm_readdatavalid_o (f_v0),
      .s0_avm_waitrequest_o   (f_w0),
      .s1_avm_write_i         (f_wr1),
      .s1_avm_read_i          (1'b0),
      .s1_avm_address_i       (f_a1),
      .s1_avm_writedata_i     (f_d1),
      .s1_avm_byteenable_i    (2'b11),
      .s1_avm_burstcount_i    (8'd1),
      .s1_avm_readdata_o      (f_rd1),
      .s1_avm_readdatavalid_o (f_v1),
      .s1_avm_waitrequest_o   (f_w1),
      .m_avm_write_o          (f_mwr),
      .m_avm_read_o           (f_mrd),
      .m_avm_address_o        (f_maddr),
      .m_avm_writedata_o      (f_mwd),
      .m_avm_byteenable_o     (f_mbe),
      .m_avm_burstcount_o     (f_mbc),
      .m_avm_readdata_i       (16'h0),
      .m_avm_readdatavalid_i  (1'b0),
      .m_avm_waitrequest_i    (1'b0)
   );

   function automatic logic [15:0] rdpat(input logic [31:0] a,
                                         input int k);
      return a[15:0] ^ a[31:16] ^ (16'(k) * 16'h0101);
   endfunction

   function automatic txn_t mk_txn(input logic wr, input logic rd,
                                   input logic [31:0] a,
                                   input logic [15:0] d,
                                   input logic [7:0] bc);
      txn_t t;
      t.wr = wr;
      t.rd = rd;
      t.addr = a;
      t.d0 = d;
      t.be = 2'b11;
      t.bc = bc;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      int   k;
      k = int'($urandom % 3);
      t.wr = (k != 1);
      t.rd = (k != 0);
      t.addr = $urandom;
      t.d0 = 16'($urandom);
      t.be = 2'($urandom);
      t.bc = 8'($urandom % 5);
      return t;
   endfunction

   function automatic int eff(input logic [7:0] bc);
      return (bc == 8'd0) ? 1 : int'(bc);
   endfunction

   task automatic push_exp(input int p, input txn_t t);
      mcmd_t c;
      c.port = 1'(p);
      c.addr = t.addr;
      c.be = t.be;
      c.bc = t.bc;
      if (t.wr) begin
         for (int k = 0; k < eff(t.bc); k++) begin
            c.wr = 1'b1;
            c.rd = 1'b0;
            c.data = t.d0 + 16'(k);
            exp_m.push_back(c);
         end
      end else begin
         c.wr = 1'b0;
         c.rd = 1'b1;
         c.data = t.d0;
         exp_m.push_back(c);
      end
   endtask

   function automatic int rd_left(input int p);
      return (p == 0) ? exp_rd0.size() : exp_rd1.size();
   endfunction

   task automatic drive(input int p, input txn_t t, output bit to);
      int n;
      int beats;
      int cyc;
      bit racc;
      n = eff(t.bc);
      beats = 0;
      cyc = 0;
      racc = 0;
      to = 0;
      s_wr[p] = t.wr;
      s_rd[p] = t.rd;
      s_addr[p] = t.addr;
      s_wd[p] = t.d0;
      s_be[p] = t.be;
      s_bc[p] = t.bc;
      if (!t.wr) begin
         for (int k = 0; k < n; k++) begin
            if (p == 0) exp_rd0.push_back(rdpat(t.addr, k));
            else exp_rd1.push_back(rdpat(t.addr, k));
         end
      end
      forever begin
         #3;
         if (!s_wait[p]) begin
            if (t.wr) beats++;
            else racc = 1;
         end
         @(negedge clk);
         cyc++;
         if (t.wr) begin
            if (beats == n) break;
            s_wd[p] = t.d0 + 16'(beats);
         end else if (racc) begin
            s_rd[p] = 1'b0;
            if (rd_left(p) == 0) break;
         end
         if (cyc > 3000) begin
            to = 1;
            break;
         end
      end
      s_wr[p] = 1'b0;
      s_rd[p] = 1'b0;
   endtask

   task automatic finish_up();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Grant order: a lone requester wins; with both, round-robin picks
   // whichever port did not go last, fixed priority always picks s0.
   task automatic run_round(input int mode, input txn_t t0,
                            input txn_t t1);
      bit to0;
      bit to1;
      int first;
      to0 = 0;
      to1 = 0;
      if (mode == 2) begin
         first = (RR != 0 && !last_g) ? 1 : 0;
         push_exp(first, first ? t1 : t0);
         push_exp(1 - first, first ? t0 : t1);
         last_g = (first == 0);
      end else begin
         push_exp(mode, mode ? t1 : t0);
         last_g = (mode == 1);
      end
      fork
         begin
            if (mode != 1) drive(0, t0, to0);
         end
         begin
            if (mode != 0) drive(1, t1, to1);
         end
      join
      if (to0 || to1) begin
         checks++;
         errors++;
         $display("FAIL round_timeout mode=%0d to0=%0b to1=%0b",
                  mode, to0, to1);
         finish_up();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (m_wr || m_rd || m_addr != 0 || m_wd != 0 ||
          m_be != 0 || m_bc != 0) begin
         errors++;
         $display("FAIL %s_mcmd got wr=%0b rd=%0b a=%h d=%h be=%b bc=%0d need 0",
                  tag, m_wr, m_rd, m_addr, m_wd, m_be, m_bc);
      end
      checks++;
      if (s_wait != 2'b11) begin
         errors++;
         $display("FAIL %s_wait got %b need 11", tag, s_wait);
      end
      checks++;
      if (s_rdv != 0 || s_rdata[0] != 0 || s_rdata[1] != 0) begin
         errors++;
         $display("FAIL %s_rdata got v=%b d0=%h d1=%h need 0",
                  tag, s_rdv, s_rdata[0], s_rdata[1]);
      end
   endtask

   task automatic chk_rd(input int p, input logic [15:0] got);
      logic [15:0] need;
      checks++;
      if (rd_left(p) == 0) begin
         errors++;
         $display("FAIL rd%0d_unexpected got %h need none", p, got);
      end else begin
         need = (p == 0) ? exp_rd0.pop_front() : exp_rd1.pop_front();
         if (got !== need) begin
            errors++;
            $display("FAIL rd%0d_data got %h need %h", p, got, need);
         end
      end
   endtask

   // m-side command monitor
   always begin
      @(negedge clk);
      #3;
      if ((m_wr || m_rd) && !m_wait) begin
         checks++;
         if (exp_m.size() == 0) begin
            errors++;
            $display("FAIL m_cmd unexpected wr=%0b rd=%0b a=%h need none",
                     m_wr, m_rd, m_addr);
         end else begin
            mon_e = exp_m.pop_front();
            if (m_wr !== mon_e.wr || m_rd !== mon_e.rd ||
                m_addr !== mon_e.addr || m_wd !== mon_e.data ||
                m_be !== mon_e.be || m_bc !== mon_e.bc ||
                s_wait[mon_e.port] !== 1'b0 ||
                s_wait[~mon_e.port] !== 1'b1) begin
               errors++;
               $display("FAIL m_cmd got wr=%0b rd=%0b a=%h d=%h be=%b bc=%0d w=%b need p%0d wr=%0b rd=%0b a=%h d=%h be=%b bc=%0d",
                        m_wr, m_rd, m_addr, m_wd, m_be, m_bc, s_wait,
                        mon_e.port, mon_e.wr, mon_e.rd, mon_e.addr,
                        mon_e.data, mon_e.be, mon_e.bc);
            end
         end
      end
   end

   // requester read-data monitor
   always begin
      @(negedge clk);
      #3;
      if (s_rdv[0]) chk_rd(0, s_rdata[0]);
      if (s_rdv[1]) chk_rd(1, s_rdata[1]);
   end

   // memory-side responder with random stalls and return gaps
   always begin
      @(negedge clk);
      m_wait = ($urandom % 4 == 0);
      if (!slave_hold && ret_q.size() > 0 && ($urandom % 3 != 0)) begin
         m_rdv = 1'b1;
         m_rdata = ret_q.pop_front();
      end else begin
         m_rdv = 1'b0;
         m_rdata = 16'($urandom);
      end
      #3;
      if (rst_n && m_rd && !m_wait) begin
         for (int k = 0; k < eff(m_bc); k++) begin
            ret_q.push_back(rdpat(m_addr, k));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  acc;
      int  ns;
      int  n0;
      int  n1;
      int  wlow;
      int  bad;
      checks = 0;
      errors = 0;
      last_g = 1;
      slave_hold = 0;
      m_wait = 1'b0;
      m_rdv = 1'b0;
      m_rdata = 16'h0;
      f_wr0 = 0;
      f_wr1 = 0;
      f_a0 = 32'h0000_0a00;
      f_a1 = 32'h0000_0b00;
      f_d0 = 16'h1111;
      f_d1 = 16'h2222;
      s_wr = 2'b00;
      s_rd = 2'b00;
      for (int p = 0; p < 2; p++) begin
         s_addr[p] = '0;
         s_wd[p] = '0;
         s_be[p] = '0;
         s_bc[p] = '0;
      end
      rst_n = 1'b0;
      s_wr[0] = 1'b1;
      s_rd[1] = 1'b1;
      s_addr[0] = 32'hdead_beef;
      s_wd[0] = 16'hbeef;
      s_be[0] = 2'b11;
      s_bc[0] = 8'd4;
      repeat (3) @(negedge clk);
      #3;
      check_idle("reset");
      @(negedge clk);
      s_wr = 2'b00;
      s_rd = 2'b00;
      s_addr[0] = '0;
      s_wd[0] = '0;
      s_be[0] = '0;
      s_bc[0] = '0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_round(0, mk_txn(1, 0, 32'h0000_1000, 16'h0a00, 8'd4),
                   mk_txn(0, 0, 32'h0, 16'h0, 8'd0));
      run_round(2, mk_txn(0, 1, 32'h0000_2000, 16'h0, 8'd2),
                   mk_txn(0, 1, 32'h0001_3000, 16'h0, 8'd2));
      run_round(1, mk_txn(0, 0, 32'h0, 16'h0, 8'd0),
                   mk_txn(1, 1, 32'h0000_4000, 16'h0c0c, 8'd0));
      for (int r = 0; r < 60; r++) begin
         run_round(int'($urandom % 3), rand_txn(), rand_txn());
      end
      run_round(0, mk_txn(1, 0, 32'h0000_5000, 16'h0505, 8'd1),
                   mk_txn(0, 0, 32'h0, 16'h0, 8'd0));

      // reset while three read beats are still owed
      slave_hold = 1;
      begin
         mcmd_t c;
         c.port = 1'b0;
         c.wr = 1'b0;
         c.rd = 1'b1;
         c.addr = 32'h0000_6000;
         c.data = 16'h6666;
         c.be = 2'b11;
         c.bc = 8'd3;
         exp_m.push_back(c);
      end
      s_rd[0] = 1'b1;
      s_addr[0] = 32'h0000_6000;
      s_wd[0] = 16'h6666;
      s_be[0] = 2'b11;
      s_bc[0] = 8'd3;
      cyc = 0;
      acc = 0;
      while (!acc && cyc < 200) begin
         #3;
         acc = !s_wait[0];
         @(negedge clk);
         cyc++;
      end
      s_rd[0] = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL rst_read_accept got none need accept");
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("midread_reset");
      @(negedge clk);
      rst_n = 1'b1;
      last_g = 1;
      slave_hold = 0;
      ns = 0;
      repeat (30) begin
         #3;
         if (s_rdv != 2'b00) ns++;
         @(negedge clk);
      end
      checks++;
      if (ns != 0) begin
         errors++;
         $display("FAIL stale_rdv got %0d need 0", ns);
      end

      run_round(2, mk_txn(1, 0, 32'h0000_7000, 16'h0707, 8'd1),
                   mk_txn(1, 0, 32'h0000_8000, 16'h0808, 8'd1));

      // fixed-priority instance, both ports requesting forever
      f_wr0 = 1;
      f_wr1 = 1;
      n0 = 0;
      n1 = 0;
      wlow = 0;
      bad = 0;
      repeat (40) begin
         #3;
         if (f_mwr) begin
            if (f_mwd == f_d0 && f_maddr == f_a0 &&
                f_mbe == 2'b11 && f_mbc == 8'd1) n0++;
            else if (f_mwd == f_d1) n1++;
         end
         if (!f_w1) wlow++;
         if (f_v0 || f_v1 || f_mrd || f_rd0 != 0 || f_rd1 != 0) bad++;
         @(negedge clk);
      end
      f_wr0 = 0;
      f_wr1 = 0;
      checks++;
      if (n0 < 19) begin
         errors++;
         $display("FAIL fixed_s0_beats got %0d need >=19", n0);
      end
      checks++;
      if (n1 != 0 || wlow != 0) begin
         errors++;
         $display("FAIL fixed_s1 got beats=%0d wait_low=%0d need 0 0",
                  n1, wlow);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL fixed_read_side got %0d need 0", bad);
      end

      repeat (4) @(negedge clk);
      checks++;
      if (exp_m.size() != 0 || exp_rd0.size() != 0 ||
          exp_rd1.size() != 0) begin
         errors++;
         $display("FAIL leftover got m=%0d r0=%0d r1=%0d need 0",
                  exp_m.size(), exp_rd0.size(), exp_rd1.size());
      end
      finish_up();
   end

endmodule
